// File: rtl/multicycle_alu.sv
// multicycle_alu: ALU with iterative MUL/DIVU, start/busy/done handshake and registered outputs
module multicycle_alu #(
  parameter int WIDTH      = 32,
  parameter bit ENABLE_DIV = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero_flag,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [WIDTH-1:0] single, step_hi, step_lo;
  logic [WIDTH:0] mul_sum, div_shift, div_diff;
  logic [CW-1:0] cnt_q, cnt_d;
  logic zero_q, zero_d, dbz_q, dbz_d, busy_q, busy_d, done_q, done_d;
  logic is_div_q, is_div_d, div_ge, accept, multi;
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign zero_flag   = zero_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign done        = done_q;
  // hi/lo hold the product halves for MUL and remainder/quotient for DIVU
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = div_shift >= {1'b0, b_q};
    step_hi   = is_div_q ? (div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]) : mul_sum[WIDTH:1];
    step_lo   = is_div_q ? {lo_q[WIDTH-2:0], div_ge} : {mul_sum[0], lo_q[WIDTH-1:1]};
    single    = '0;
    case (op)
      3'b000:  single = src_a & src_b;
      3'b001:  single = src_a | src_b;
      3'b010:  single = src_a + src_b;
      3'b100:  single = src_a - src_b;
      3'b110:  single = WIDTH'(src_a < src_b);
      3'b111:  single = WIDTH'($signed(src_a) < $signed(src_b));
      default: single = '0;
    endcase
    multi       = (op == 3'b101) || (op == 3'b011 && ENABLE_DIV);
    accept      = start && state_q != RUN;
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    dbz_d       = dbz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    b_d         = b_q;
    is_div_d    = is_div_q;
    cnt_d       = cnt_q;
    if (accept) begin
      dbz_d = 1'b0;
      if (multi) begin
        hi_d     = '0;
        lo_d     = src_a;
        b_d      = src_b;
        is_div_d = op == 3'b011;
        cnt_d    = '0;
        busy_d   = 1'b1;
        state_d  = RUN;
      end else begin
        result_d    = single;
        result_hi_d = '0;
        zero_d      = single == '0;
        done_d      = 1'b1;
        state_d     = DONE;
      end
    end else if (state_q == RUN) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + 1'b1;
      // a zero divisor naturally yields all-ones quotient and remainder = a
      if (cnt_q == CW'(WIDTH - 1)) begin
        result_d    = step_lo;
        result_hi_d = step_hi;
        zero_d      = step_lo == '0;
        dbz_d       = is_div_q && b_q == '0;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        state_d     = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      b_q         <= '0;
      is_div_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      b_q         <= b_d;
      is_div_q    <= is_div_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: random and directed scoreboard bench for multicycle_alu
module tb_multicycle_alu;
  localparam int W = 32;
  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] hi;
    logic         dbz;
    logic         zero;
    bit           multi;
    int           cyc;
  } exp_t;
  logic clk = 0, rst = 1, start = 0;
  logic [2:0] op = 0;
  logic [W-1:0] src_a = 0, src_b = 0;
  logic [W-1:0] result, result_hi;
  logic zero_flag, div_by_zero, busy, done;
  int n_chk = 0, n_fail = 0, cyc = 0, busy_cnt = 0, done_cnt = 0, snap;
  exp_t sb[$];
  exp_t mon_e;
  multicycle_alu #(.WIDTH(W), .ENABLE_DIV(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .result(result), .result_hi(result_hi), .zero_flag(zero_flag),
    .div_by_zero(div_by_zero), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    e.hi = 0; e.dbz = 0; e.r = 0; e.cyc = 0;
    e.multi = (o == 3'd5 || o == 3'd3);
    case (o)
      3'd0: e.r = a & b;
      3'd1: e.r = a | b;
      3'd2: e.r = a + b;
      3'd3: if (b == 0) begin e.r = {W{1'b1}}; e.hi = a; e.dbz = 1; end
            else begin e.r = a / b; e.hi = a % b; end
      3'd4: e.r = a - b;
      3'd5: begin p = (2*W)'(a) * (2*W)'(b); e.r = p[W-1:0]; e.hi = p[2*W-1:W]; end
      3'd6: e.r = (a < b) ? 1 : 0;
      default: e.r = ($signed(a) < $signed(b)) ? 1 : 0;
    endcase
    e.zero = (e.r == 0);
    return e;
  endfunction
  always @(negedge clk) begin
    if (rst) busy_cnt = 0;
    else begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: got done=1 with no op pending at cycle %0d", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("result", result, mon_e.r);
          chk("result_hi", result_hi, mon_e.hi);
          chk("div_by_zero", div_by_zero, mon_e.dbz);
          chk("zero_flag", zero_flag, mon_e.zero);
          chk("busy_at_done", busy, 0);
          chk("busy_cycles", busy_cnt, mon_e.multi ? W : 0);
          chk("done_cycle", cyc, mon_e.cyc);
        end
        busy_cnt = 0;
      end
    end
  end
  // caller is at a negedge; returns 1 time unit after the accept edge
  task automatic drive(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    exp_t e;
    start = 1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 0;
    if (push) begin
      e = model(o, a, b);
      e.cyc = cyc + (e.multi ? W : 0);
      sb.push_back(e);
    end
  endtask
  task automatic wait_done();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("timeout_pending", sb.size(), 0);
    sb.delete();
  endtask
  task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    drive(o, a, b, 1);
    wait_done();
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_result_hi", result_hi, 0);
    chk("rst_zero", zero_flag, 1);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk) rst = 0;
    run(3'd2, 5, 7);
    run(3'd4, 9, 9);
    run(3'd4, 0, 1);
    run(3'd5, 32'hFFFF_FFFF, 2);
    run(3'd3, 100, 7);
    run(3'd3, 5, 0);
    run(3'd2, 1, 1);
    run(3'd7, 32'hFFFF_FFFF, 1);
    run(3'd6, 32'hFFFF_FFFF, 1);
    run(3'd7, 3, 32'hFFFF_FFFE);
    run(3'd6, 3, 32'hFFFF_FFFE);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // start during busy must be dropped
    @(negedge clk);
    drive(3'd5, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    repeat (4) @(negedge clk);
    start = 1; op = 3'd2; src_a = 1; src_b = 1;
    @(negedge clk) start = 0;
    wait_done();
    // back-to-back: new op accepted in the done cycle
    @(negedge clk);
    drive(3'd5, 32'hDEAD_BEEF, 32'h0000_0010, 1);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    drive(3'd2, 40, 2, 1);
    wait_done();
    // reset aborts an in-flight multiply
    @(negedge clk);
    drive(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    repeat (9) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_result_hi", result_hi, 0);
    chk("abort_zero", zero_flag, 1);
    snap = done_cnt;
    @(negedge clk) rst = 0;
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_cnt, snap);
    // reset wins over a simultaneous start
    rst = 1; start = 1; op = 3'd2; src_a = 1; src_b = 1;
    @(posedge clk); #1;
    chk("rst_start_done", done, 0);
    chk("rst_start_busy", busy, 0);
    @(negedge clk) begin rst = 0; start = 0; end
    repeat (3) @(negedge clk);
    chk("rst_start_no_done", done_cnt, snap);
    run(3'd2, 1, 1);
    for (int i = 0; i < 40; i++) begin
      logic [2:0] o;
      logic [W-1:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = W'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run(o, a, b);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
